led_pattern_decoder: RTL

Parametrised successor to the switch-to-LED one-hot decoder. It maps a SEL_W-bit selector onto LED_N registered LED lines. Output is gated by a 3-bit enable code and has four display modes: one-hot, thermometer bar, blink and chase. Blink and chase are timed by an internal divider. The block sits between the board switch inputs and the LED pins.

---
 rtl/led_pattern_decoder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/led_pattern_decoder.sv
// led_pattern_decoder: maps a selector onto LED_N registered LED lines.
// There are four display modes: one-hot, thermometer, blink and chase.
// Blink and chase are timed by an internal BLINK_DIV divider.
// Each LED line has its own small lit-decision lane. The top level holds the shared
// divider, the blink phase, the chase position and the output register.

// Decides whether one LED line is lit. The decision is polarity-free.
module led_pattern_lane #(
    parameter int SEL_W = 3,
    parameter int IDX   = 0
) (
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_ok,
    input  logic             phase,
    input  logic [SEL_W-1:0] pos,
    output logic             lit
);
    localparam logic [SEL_W-1:0] IDX_V = SEL_W'(IDX);

    logic is_sel;
    assign is_sel = sel_ok && (sel == IDX_V);

    // Per-mode lit decision for this line
    always_comb begin
        lit = 1'b0;
        unique case (mode)
            2'd0: lit = is_sel;
            2'd1: lit = !sel_ok || (IDX_V <= sel);
            2'd2: lit = phase && is_sel;
            2'd3: lit = (pos == IDX_V);
            default: lit = 1'b0;
        endcase
    end
endmodule

module led_pattern_decoder #(
    parameter int         SEL_W      = 3,
    parameter int         LED_N      = 8,
    parameter logic [2:0] EN_CODE    = 3'd4,
    parameter int         BLINK_DIV  = 4,
    parameter int         ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       enable,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    output logic [LED_N-1:0] led
);
    localparam int               CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
    localparam logic [SEL_W-1:0] POS_MAX = SEL_W'(LED_N - 1);
    localparam logic [SEL_W:0]   LED_LIM = (SEL_W + 1)'(LED_N);
    localparam logic [LED_N-1:0] LED_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    // Divider and pattern state
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             phase, phase_d;
    logic [SEL_W-1:0] pos, pos_d;
    logic [1:0]       mode_q;
    logic             first_q;

    logic             active, sel_ok, restart, tick;
    logic [LED_N-1:0] lane_lit, lit_d;

    assign active = (enable == EN_CODE);
    assign sel_ok = ({1'b0, sel} < LED_LIM);

    // Next-state: restart on disable, mode change or first edge after reset
    always_comb begin
        cnt_d   = cnt;
        phase_d = phase;
        pos_d   = pos;
        restart = !active || (mode != mode_q) || first_q;
        tick    = (cnt == CNT_MAX);
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b1;
            pos_d   = sel_ok ? sel : '0;
        end else begin
            cnt_d = tick ? '0 : cnt + 1'b1;
            if (tick) begin
                phase_d = ~phase;
                pos_d   = (pos == POS_MAX) ? '0 : pos + 1'b1;
            end
        end
    end

    // One lane per LED line, fed with the next-state phase/pos so the
    // output register shows the pattern of the edge that produced it.
    for (genvar i = 0; i < LED_N; i++) begin : g_lane
        led_pattern_lane #(
            .SEL_W (SEL_W),
            .IDX   (i)
        ) u_lane (
            .mode   (mode),
            .sel    (sel),
            .sel_ok (sel_ok),
            .phase  (phase_d),
            .pos    (pos_d),
            .lit    (lane_lit[i])
        );
    end

    // Inactive display wins over every mode, including a same-edge mode change
    assign lit_d = active ? lane_lit : '0;

    // State and output registers; polarity applied only at the pin drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            phase   <= 1'b1;
            pos     <= '0;
            mode_q  <= 2'd0;
            first_q <= 1'b1;
            led     <= LED_OFF;
        end else begin
            cnt     <= cnt_d;
            phase   <= phase_d;
            pos     <= pos_d;
            mode_q  <= mode;
            first_q <= 1'b0;
            led     <= (ACTIVE_LOW != 0) ? ~lit_d : lit_d;
        end
    end
endmodule
